parking_gate_ctrl: RTL and testbench

Sequencing controller for the four-slot parking lot. Arbitrates entry and exit requests onto a single shared gate and allocates the lowest free slot on entry. Tracks per-slot occupancy and holds the gate open for a fixed time. Its occupancy vector is the 4-bit input to the lot's capacity/display logic; `free_cnt` and `full` are generated internally for admission decisions.

---
 rtl/parking_pkg.sv | 20 ++
 rtl/slot_alloc.sv | 32 +++
 rtl/parking_gate_ctrl.sv | 124 ++++++++++++
 tb/tb_parking_gate_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and sizing for the four-slot parking gate controller.
// Contents: slot count, slot index / free-count widths, gate FSM state encoding.
// No logic; imported by slot_alloc and parking_gate_ctrl.
package parking_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;
    localparam int CNT_W     = 3;

    typedef logic [SLOT_W-1:0]    slot_t;
    typedef logic [NUM_SLOTS-1:0] occ_t;
    typedef logic [CNT_W-1:0]     cnt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        CLOSE = 2'd2
    } state_t;

endpackage

// File: rtl/slot_alloc.sv
// Slot allocator: lowest free slot index, free-slot count and lot-full flag.
// Latency: purely combinational, zero cycles.
// Ports: occupancy in; lowest_free, free_cnt, full out. No flow control.
module slot_alloc
    import parking_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] occupancy,
    output logic [SLOT_W-1:0]    lowest_free,
    output logic [CNT_W-1:0]     free_cnt,
    output logic                 full
);

    logic found;

    always_comb begin
        lowest_free = '0;
        free_cnt    = '0;
        found       = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!occupancy[i]) begin
                free_cnt = free_cnt + 3'd1;
                // first zero bit scanning upward wins
                if (!found) begin
                    lowest_free = SLOT_W'(i);
                    found       = 1'b1;
                end
            end
        end
        full = &occupancy;
    end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking gate sequencer: exit-priority arbitration, lowest-slot allocation, timed gate.
// Latency: grant/occupancy visible one edge after the request; gate open GATE_CYCLES, then one settle cycle.
// Ports: clk/rst, entry_req/exit_req/exit_slot in; gate, grant/deny/err pulses, occupancy status out. Requests ignored while busy.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 8
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 entry_req,
    input  logic                 exit_req,
    input  logic [SLOT_W-1:0]    exit_slot,
    output logic                 gate_open,
    output logic                 gate_dir,
    output logic                 grant,
    output logic [SLOT_W-1:0]    assigned_slot,
    output logic                 deny,
    output logic                 err,
    output logic [NUM_SLOTS-1:0] occupancy,
    output logic [CNT_W-1:0]     free_cnt,
    output logic                 full,
    output logic                 busy
);

    // counter starts one below the open time so OPEN spans exactly GATE_CYCLES cycles
    localparam logic [7:0] GATE_LOAD = 8'(GATE_CYCLES - 1);

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [NUM_SLOTS-1:0] occ_q, occ_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                dir_q, dir_d;
    logic                grant_q, grant_d;
    logic                deny_q, deny_d;
    logic                err_q, err_d;
    logic [SLOT_W-1:0]   lowest_free;

    slot_alloc u_slot_alloc (
        .occupancy   (occ_q),
        .lowest_free (lowest_free),
        .free_cnt    (free_cnt),
        .full        (full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            occ_q   <= '0;
            slot_q  <= '0;
            dir_q   <= 1'b0;
            grant_q <= 1'b0;
            deny_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            occ_q   <= occ_d;
            slot_q  <= slot_d;
            dir_q   <= dir_d;
            grant_q <= grant_d;
            deny_q  <= deny_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        occ_d   = occ_q;
        slot_d  = slot_q;
        dir_d   = dir_q;
        grant_d = 1'b0;
        deny_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // exit always wins; a bad exit still blocks entry for this cycle
                if (exit_req) begin
                    if (occ_q[exit_slot]) begin
                        occ_d[exit_slot] = 1'b0;
                        grant_d          = 1'b1;
                        dir_d            = 1'b0;
                        cnt_d            = GATE_LOAD;
                        state_d          = OPEN;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (entry_req) begin
                    if (!full) begin
                        occ_d[lowest_free] = 1'b1;
                        slot_d             = lowest_free;
                        grant_d            = 1'b1;
                        dir_d              = 1'b1;
                        cnt_d              = GATE_LOAD;
                        state_d            = OPEN;
                    end else begin
                        deny_d = 1'b1;
                    end
                end
            end
            OPEN: begin
                if (cnt_q == 8'd0) begin
                    state_d = CLOSE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            CLOSE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign gate_open     = (state_q == OPEN);
    assign busy          = (state_q != IDLE);
    assign gate_dir      = dir_q;
    assign grant         = grant_q;
    assign deny          = deny_q;
    assign err           = err_q;
    assign assigned_slot = slot_q;
    assign occupancy     = occ_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: directed requests with hand-computed expected events.
// Expected grant/deny/err events and gate-open lengths are queued at stimulus time;
// a negedge monitor pops and compares whenever the DUT pulses or closes the gate.
module tb_parking_gate_ctrl;

    localparam logic [1:0] K_GRANT = 2'd0;
    localparam logic [1:0] K_DENY  = 2'd1;
    localparam logic [1:0] K_ERR   = 2'd2;
    localparam logic [1:0] K_BAD   = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic       dir;
        logic [1:0] slot;
        logic [3:0] occ;
        logic [2:0] free;
        logic       full;
        logic       busy;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance, GATE_CYCLES = 8
    logic       rst, entry_req, exit_req;
    logic [1:0] exit_slot;
    logic       gate_open, gate_dir, grant, deny, err, full, busy;
    logic [1:0] assigned_slot;
    logic [3:0] occupancy;
    logic [2:0] free_cnt;

    // second instance, GATE_CYCLES = 1
    logic       entry_b, exit_b;
    logic [1:0] exit_slot_b;
    logic       gate_open_b, gate_dir_b, grant_b, deny_b, err_b, full_b, busy_b;
    logic [1:0] assigned_slot_b;
    logic [3:0] occupancy_b;
    logic [2:0] free_cnt_b;

    parking_gate_ctrl #(.GATE_CYCLES(8)) u_dut (
        .clk(clk), .rst(rst), .entry_req(entry_req), .exit_req(exit_req), .exit_slot(exit_slot),
        .gate_open(gate_open), .gate_dir(gate_dir), .grant(grant), .assigned_slot(assigned_slot),
        .deny(deny), .err(err), .occupancy(occupancy), .free_cnt(free_cnt), .full(full), .busy(busy)
    );

    parking_gate_ctrl #(.GATE_CYCLES(1)) u_dut_b (
        .clk(clk), .rst(rst), .entry_req(entry_b), .exit_req(exit_b), .exit_slot(exit_slot_b),
        .gate_open(gate_open_b), .gate_dir(gate_dir_b), .grant(grant_b), .assigned_slot(assigned_slot_b),
        .deny(deny_b), .err(err_b), .occupancy(occupancy_b), .free_cnt(free_cnt_b), .full(full_b), .busy(busy_b)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    logic mon_en   = 1'b0;
    ev_t  exp_q[$];
    int   gate_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input logic [1:0] kind, input logic dir, input logic [1:0] slot,
                           input logic [3:0] occ, input logic [2:0] free, input logic fl, input logic bsy);
        ev_t e;
        e.kind = kind;
        e.dir  = (kind == K_GRANT) ? dir  : 1'b0;
        e.slot = (kind == K_GRANT) ? slot : 2'd0;
        e.occ  = occ;
        e.free = free;
        e.full = fl;
        e.busy = bsy;
        exp_q.push_back(e);
    endtask

    // event monitor: every grant/deny/err pulse must match the next queued expectation
    always @(negedge clk) begin
        if (mon_en && (grant || deny || err)) begin
            ev_t a;
            ev_t e;
            case ({grant, deny, err})
                3'b100:  a.kind = K_GRANT;
                3'b010:  a.kind = K_DENY;
                3'b001:  a.kind = K_ERR;
                default: a.kind = K_BAD;
            endcase
            a.dir  = (a.kind == K_GRANT) ? gate_dir      : 1'b0;
            a.slot = (a.kind == K_GRANT) ? assigned_slot : 2'd0;
            a.occ  = occupancy;
            a.free = free_cnt;
            a.full = full;
            a.busy = busy;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: got 0x%0h, expected no event", a);
            end else begin
                e = exp_q.pop_front();
                check("event", 32'(a), 32'(e));
            end
        end
    end

    // gate-length monitor: measures each open interval when the gate drops
    int open_len = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (gate_open === 1'b1) begin
                open_len++;
            end else if (open_len > 0) begin
                if (gate_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_gate: got open for %0d cycles, expected none", open_len);
                end else begin
                    check("gate_len", 32'(open_len), 32'(gate_q.pop_front()));
                end
                open_len = 0;
            end
        end
    end

    task automatic pulse_req(input logic ent, input logic ext, input logic [1:0] slot);
        @(posedge clk); #1;
        entry_req = ent; exit_req = ext; exit_slot = slot;
        @(posedge clk); #1;
        entry_req = 1'b0; exit_req = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < 100);
        check("wait_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] gbits, obits, bbits;
        rst = 1'b1; entry_req = 1'b0; exit_req = 1'b0; exit_slot = 2'd0;
        entry_b = 1'b0; exit_b = 1'b0; exit_slot_b = 2'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        // reset state
        @(negedge clk);
        check("rst_occ",  32'(occupancy), 32'h0);
        check("rst_free", 32'(free_cnt), 32'd4);
        check("rst_outs", 32'({full, gate_open, gate_dir, grant, deny, err, busy}), 32'h0);
        check("rst_slot", 32'(assigned_slot), 32'd0);

        // GATE_CYCLES=1 with a held entry: grant, open 1, close 1, idle 1, re-grant
        @(posedge clk); #1 entry_b = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            gbits[i] = grant_b;
            obits[i] = gate_open_b;
            bbits[i] = busy_b;
        end
        entry_b = 1'b0;
        check("g1_grant_pattern", 32'(gbits), 32'(7'b1001001));
        check("g1_gate_pattern",  32'(obits), 32'(7'b1001001));
        check("g1_busy_pattern",  32'(bbits), 32'(7'b1011011));
        check("g1_slot_occ",      32'({assigned_slot_b, occupancy_b}), 32'({2'd2, 4'b0111}));

        // four sequential entries fill slots 0..3
        push_ev(K_GRANT, 1'b1, 2'd0, 4'b0001, 3'd3, 1'b0, 1'b1);
        push_ev(K_GRANT, 1'b1, 2'd1, 4'b0011, 3'd2, 1'b0, 1'b1);
        push_ev(K_GRANT, 1'b1, 2'd2, 4'b0111, 3'd1, 1'b0, 1'b1);
        push_ev(K_GRANT, 1'b1, 2'd3, 4'b1111, 3'd0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            gate_q.push_back(8);
            pulse_req(1'b1, 1'b0, 2'd0);
            wait_idle();
        end

        // full lot, entry held three cycles: three denies
        for (int i = 0; i < 3; i++) push_ev(K_DENY, 1'b0, 2'd0, 4'b1111, 3'd0, 1'b1, 1'b0);
        @(posedge clk); #1 entry_req = 1'b1;
        repeat (3) @(posedge clk);
        #1 entry_req = 1'b0;
        @(negedge clk);
        check("deny_occ", 32'(occupancy), 32'(4'b1111));

        // simultaneous exit(2)+entry: exit first, then the held entry takes slot 2
        push_ev(K_GRANT, 1'b0, 2'd3, 4'b1011, 3'd1, 1'b0, 1'b1);
        push_ev(K_GRANT, 1'b1, 2'd2, 4'b1111, 3'd0, 1'b1, 1'b1);
        gate_q.push_back(8);
        gate_q.push_back(8);
        @(posedge clk); #1;
        entry_req = 1'b1; exit_req = 1'b1; exit_slot = 2'd2;
        @(posedge clk); #1 exit_req = 1'b0;
        repeat (10) @(posedge clk);
        #1 entry_req = 1'b0;
        wait_idle();

        // vacate 1 and 3 to reach 0101, then exit an empty slot
        push_ev(K_GRANT, 1'b0, 2'd2, 4'b1101, 3'd1, 1'b0, 1'b1);
        push_ev(K_GRANT, 1'b0, 2'd2, 4'b0101, 3'd2, 1'b0, 1'b1);
        gate_q.push_back(8);
        gate_q.push_back(8);
        pulse_req(1'b0, 1'b1, 2'd1);
        wait_idle();
        pulse_req(1'b0, 1'b1, 2'd3);
        wait_idle();
        push_ev(K_ERR, 1'b0, 2'd0, 4'b0101, 3'd2, 1'b0, 1'b0);
        pulse_req(1'b0, 1'b1, 2'd1);
        @(negedge clk);
        check("err_state", 32'({busy, gate_open, occupancy}), 32'({1'b0, 1'b0, 4'b0101}));

        // reset during the 4th OPEN cycle of an entry
        push_ev(K_GRANT, 1'b1, 2'd1, 4'b0111, 3'd1, 1'b0, 1'b1);
        gate_q.push_back(4);
        @(posedge clk); #1 entry_req = 1'b1;
        @(posedge clk); #1 entry_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rstmid_gate", 32'(gate_open), 32'd0);
        check("rstmid_occ",  32'(occupancy), 32'h0);
        check("rstmid_idle", 32'(busy), 32'd0);
        check("rstmid_free", 32'({full, free_cnt}), 32'({1'b0, 3'd4}));

        repeat (3) @(negedge clk);
        check("events_drained", 32'(exp_q.size()), 32'd0);
        check("gates_drained",  32'(gate_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
